// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if: host command/response handshakes and memory host port of mem_req_queue
// Ports: cmd_* (host command, valid/ready), rsp_* (response, valid/ready),
//        mem_* (memory controller host port), q_count/busy (status).
// Modports: slave = the queue itself, master = the host/memory side driving it.
interface mem_req_queue_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
);
  logic cmd_valid, cmd_ready, cmd_wr_en;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic mem_req, mem_wr_en, mem_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [$clog2(DEPTH):0] q_count;
  logic busy;
  modport slave (
    input cmd_valid, cmd_wr_en, cmd_addr, cmd_wdata, rsp_ready, mem_rdata, mem_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_wr, rsp_err,
    output mem_req, mem_wr_en, mem_addr, mem_wdata, q_count, busy
  );
  modport master (
    output cmd_valid, cmd_wr_en, cmd_addr, cmd_wdata, rsp_ready, mem_rdata, mem_ack,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_wr, rsp_err,
    input mem_req, mem_wr_en, mem_addr, mem_wdata, q_count, busy
  );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order command FIFO feeding a one-outstanding-request memory FSM
// Ports: clk (rising edge), rst_n (asynchronous active-low),
//        bus (mem_req_queue_if.slave): cmd_* in, rsp_* out, mem_* host port, q_count, busy.
// Optional: define MEM_REQ_QUEUE_TIMEOUT_EN to end a WAIT after TIMEOUT cycles
//           without mem_ack, responding with rsp_err=1.
module mem_req_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  mem_req_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [EW-1:0] fifo [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic iss_wr, rsp_wr, rsp_err;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [DATA_WIDTH-1:0] iss_wdata, rsp_rdata;
  logic full, has, push, pop, rsp_hs, ack, tmo;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("mem_req_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif

  // pop uses the registered count, so an entry pushed at an edge is never popped at that same edge
  always_comb begin
    full = count == CW'(DEPTH);
    has = count != '0;
    push = bus.cmd_valid && !full;
    rsp_hs = state == RESP && bus.rsp_ready;
    pop = has && (state == IDLE || rsp_hs);
    ack = state == WAIT && bus.mem_ack;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    tmo = state == WAIT && !bus.mem_ack && tcnt == TW'(TIMEOUT - 1);
`else
    tmo = 1'b0;
`endif
    state_n = (state == IDLE && has) ? ISSUE :
              (state == ISSUE) ? WAIT :
              (ack || tmo) ? RESP :
              rsp_hs ? (has ? ISSUE : IDLE) : state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk)
    if (push) fifo[wptr] <= {bus.cmd_wr_en, bus.cmd_addr, bus.cmd_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      iss_wr <= 1'b0;
      iss_addr <= '0;
      iss_wdata <= '0;
      rsp_wr <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        {iss_wr, iss_addr, iss_wdata} <= fifo[rptr];
      end
      count <= count + CW'(push) - CW'(pop);
      if (ack || tmo) begin
        rsp_wr <= iss_wr;
        rsp_rdata <= (ack && !iss_wr) ? bus.mem_rdata : '0;
      end
    end
  end

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
  // counter is held at zero outside WAIT, so every WAIT entry starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
      if (ack || tmo) rsp_err <= tmo;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = !full;
  assign bus.mem_req = state == ISSUE;
  assign bus.mem_wr_en = iss_wr;
  assign bus.mem_addr = iss_addr;
  assign bus.mem_wdata = iss_wdata;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_wr = rsp_wr;
  assign bus.rsp_err = rsp_err;
  assign bus.q_count = count;
  assign bus.busy = state != IDLE || has;
endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: scoreboard bench for mem_req_queue with a registered-ack memory model
module tb_mem_req_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_queue_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4)) b();
  mem_req_queue #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  int n_vec = 0, n_bad = 0, cyc = 0, last_hs = -1;
  bit ack_en = 1'b1, chk_sp = 1'b0, prev_hold = 1'b0;
  logic [31:0] mem [256];
  logic [33:0] exp_q [$];
  logic [33:0] held, cur;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    b.mem_ack <= ack_en && b.mem_req;
    b.mem_rdata <= mem[b.mem_addr[7:0]];
    if (b.mem_req && b.mem_wr_en) mem[b.mem_addr[7:0]] <= b.mem_wdata;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_hold = 1'b0;
    else if (b.rsp_valid) begin
      cur = {b.rsp_err, b.rsp_wr, b.rsp_rdata};
      if (prev_hold) check("rsp_stable", 64'(cur), 64'(held));
      if (b.rsp_ready) begin
        prev_hold = 1'b0;
        if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else check("rsp", 64'(cur), 64'(exp_q.pop_front()));
        if (chk_sp && last_hs >= 0) check("rsp_spacing", 64'(cyc - last_hs), 64'd3);
        last_hs = cyc;
      end else begin
        prev_hold = 1'b1;
        held = cur;
      end
    end
  end

  task automatic push(input logic wr, input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input bit exp_rsp);
    bit ok = 1'b0;
    b.cmd_valid = 1'b1;
    b.cmd_wr_en = wr;
    b.cmd_addr = a;
    b.cmd_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = b.cmd_ready;
      @(posedge clk);
      #1;
    end
    b.cmd_valid = 1'b0;
    if (!ok) check("push_timeout", 64'd0, 64'd1);
    else if (exp_rsp) exp_q.push_back({ee, wr, er});
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !b.busy) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b.cmd_valid = 1'b0;
    b.cmd_wr_en = 1'b0;
    b.cmd_addr = '0;
    b.cmd_wdata = '0;
    b.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(b.cmd_ready), 64'd1);
    check("rst_mem_req", 64'(b.mem_req), 64'd0);
    check("rst_q_count", 64'(b.q_count), 64'd0);
    check("rst_busy", 64'(b.busy), 64'd0);
    check("rst_rsp_valid", 64'(b.rsp_valid), 64'd0);
    check("rst_rsp", 64'({b.rsp_err, b.rsp_wr, b.rsp_rdata}), 64'd0);
    check("rst_mem_out", 64'({b.mem_wr_en, b.mem_addr, b.mem_wdata}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    push(1'b0, 16'h0005, 32'h0, 32'd5, 1'b0, 1'b1);
    @(negedge clk);
    check("c0_mem_req", 64'(b.mem_req), 64'd0);
    @(negedge clk);
    check("c1_mem_req", 64'(b.mem_req), 64'd1);
    check("c1_mem_addr", 64'(b.mem_addr), 64'h5);
    check("c1_mem_wr_en", 64'(b.mem_wr_en), 64'd0);
    @(negedge clk);
    check("c2_mem_req", 64'(b.mem_req), 64'd0);
    check("c2_rsp_valid", 64'(b.rsp_valid), 64'd0);
    @(negedge clk);
    check("c3_rsp_valid", 64'(b.rsp_valid), 64'd1);
    drain();

    push(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    push(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    drain();

    b.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 16'(16'h20 + i), 32'h0, 32'(32'h20 + i), 1'b0, 1'b1);
    b.cmd_valid = 1'b1;
    b.cmd_addr = 16'h0099;
    @(negedge clk);
    check("full_q_count", 64'(b.q_count), 64'd4);
    check("full_cmd_ready", 64'(b.cmd_ready), 64'd0);
    check("full_rsp_valid", 64'(b.rsp_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("full_hold_cmd_ready", 64'(b.cmd_ready), 64'd0);
    check("full_hold_q_count", 64'(b.q_count), 64'd4);
    @(posedge clk);
    #1;
    b.cmd_valid = 1'b0;
    chk_sp = 1'b1;
    last_hs = -1;
    b.rsp_ready = 1'b1;
    drain();
    chk_sp = 1'b0;

    for (int i = 0; i < 10; i++) push(1'b0, 16'(i), 32'h0, 32'(i), 1'b0, 1'b1);
    drain();

    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 16'(16'h40 + i), 32'h0, 32'(32'h40 + i), 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("wait_q_count", 64'(b.q_count), 64'd2);
    check("wait_rsp_valid", 64'(b.rsp_valid), 64'd0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_mem_req", 64'(b.mem_req), 64'd0);
    check("mid_rst_q_count", 64'(b.q_count), 64'd0);
    check("mid_rst_rsp_valid", 64'(b.rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(b.busy), 64'd0);
    check("mid_rst_cmd_ready", 64'(b.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    ack_en = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_q_count", 64'(b.q_count), 64'd0);
    check("post_rst_busy", 64'(b.busy), 64'd0);

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    ack_en = 1'b0;
    push(1'b0, 16'h0007, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (18) @(negedge clk);
    check("tmo_c17_rsp_valid", 64'(b.rsp_valid), 64'd0);
    @(negedge clk);
    check("tmo_c18_rsp_valid", 64'(b.rsp_valid), 64'd1);
    drain();
    ack_en = 1'b1;
`else
    ack_en = 1'b0;
    push(1'b0, 16'h0007, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("no_tmo_rsp_valid", 64'(b.rsp_valid), 64'd0);
    check("no_tmo_busy", 64'(b.busy), 64'd1);
    check("no_tmo_mem_req", 64'(b.mem_req), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("no_tmo_rst_busy", 64'(b.busy), 64'd0);
    @(posedge clk);
    #1;
    ack_en = 1'b1;
    rst_n = 1'b1;
`endif

    push(1'b0, 16'h0003, 32'h0, 32'd3, 1'b0, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
